// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronised rx line, mid-bit sampling, one-byte holding
// register with data_ready handshake and sticky framing/overrun flags.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 289,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       n_Rst,
    input  logic       rx,
    input  logic       data_read,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             ready_q, ready_d;
    logic             fe_q, fe_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;
    logic             load_c;
    logic             fe_set_c;

    assign rx_s = sync2_q;

    // State, datapath and synchroniser registers
    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
        end
    end

    // Next-state, bit sampling and handshake flags
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        load_c    = 1'b0;
        fe_set_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        load_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_set_c = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so it is never mistaken for a start bit
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load coinciding with data_read keeps the new byte and suppresses overrun
        rx_data_d = load_c ? shift_q : rx_data_q;
        ready_d   = load_c | (ready_q & ~data_read);
        ovr_d     = (ovr_q & ~data_read) | (load_c & ready_q & ~data_read);
        fe_d      = (fe_q & ~data_read) | fe_set_c;
        busy_d    = (state_d != S_IDLE);
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign framing_error = fe_q;
    assign overrun_error = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a frame table plus hand-timed sequences for
// exact latency, glitch, break, read-in-load-cycle and mid-frame reset.
module tb_uart_rx_frame;

    localparam int CPB  = 289;
    localparam int HALF = 144;
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       clk;
    logic       n_Rst;
    logic       rx;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int checks;
    int failures;

    uart_rx_frame dut (
        .clk           (clk),
        .n_Rst         (n_Rst),
        .rx            (rx),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge; a low stop bit can be held extra cycles
    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            repeat (hold_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, rx_data, 8'h00);
        chk({tag, "_ready"}, 8'(data_ready), 8'h0);
        chk({tag, "_fe"}, 8'(framing_error), 8'h0);
        chk({tag, "_ovr"}, 8'(overrun_error), 8'h0);
        chk({tag, "_busy"}, 8'(busy), 8'h0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_Rst     = 1'b0;
        rx        = 1'b1;
        data_read = 1'b0;

        vecs[0] = '{8'h84, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        n_Rst = 1'b1;
        repeat (4) @(negedge clk);

        // Exact load latency and busy fall relative to the rx falling edge
        fork
            send_frame(8'h84, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                chk("lat_pre_ready", 8'(data_ready), 8'h0);
                chk("lat_pre_busy", 8'(busy), 8'h1);
                @(posedge clk);
                #1;
                chk("lat_ready", 8'(data_ready), 8'h1);
                chk("lat_data", rx_data, 8'h84);
                chk("lat_busy", 8'(busy), 8'h0);
                chk("lat_fe", 8'(framing_error), 8'h0);
                chk("lat_ovr", 8'(overrun_error), 8'h0);
            end
        join
        pulse_read();
        chk("lat_read_ready", 8'(data_ready), 8'h0);

        // Short low glitch is rejected at the half-bit check
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_busy_hi", 8'(busy), 8'h1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_busy_lo", 8'(busy), 8'h0);
        chk("glitch_ready", 8'(data_ready), 8'h0);
        chk("glitch_fe", 8'(framing_error), 8'h0);
        chk("glitch_ovr", 8'(overrun_error), 8'h0);

        // Frame table
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, 0);
            chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
            chk($sformatf("vec%0d_ready", v), 8'(data_ready), 8'(vecs[v].exp_ready));
            chk($sformatf("vec%0d_fe", v), 8'(framing_error), 8'(vecs[v].exp_fe));
            chk($sformatf("vec%0d_ovr", v), 8'(overrun_error), 8'(vecs[v].exp_ovr));
            chk($sformatf("vec%0d_busy", v), 8'(busy), 8'h0);
            if (vecs[v].rd) begin
                pulse_read();
                chk($sformatf("vec%0d_rd_ready", v), 8'(data_ready), 8'h0);
                chk($sformatf("vec%0d_rd_fe", v), 8'(framing_error), 8'h0);
                chk($sformatf("vec%0d_rd_ovr", v), 8'(overrun_error), 8'h0);
            end
        end

        // Break: bad stop bit then line held low, no false start during the hold
        send_frame(8'h3C, 1'b0, 1000);
        chk("brk_fe", 8'(framing_error), 8'h1);
        chk("brk_ready", 8'(data_ready), 8'h0);
        chk("brk_busy", 8'(busy), 8'h0);
        chk("brk_data", rx_data, 8'h55);
        send_frame(8'h55, 1'b1, 0);
        chk("brk2_data", rx_data, 8'h55);
        chk("brk2_ready", 8'(data_ready), 8'h1);
        chk("brk2_fe", 8'(framing_error), 8'h1);

        // data_read in the exact load cycle of a second byte
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
            end
        join
        chk("ldrd_ready", 8'(data_ready), 8'h1);
        chk("ldrd_data", rx_data, 8'hA5);
        chk("ldrd_ovr", 8'(overrun_error), 8'h0);
        chk("ldrd_fe", 8'(framing_error), 8'h0);

        // Reset during data bit 3 of 0xFF discards the partial byte
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                repeat (4 * CPB + 150) @(posedge clk);
                @(negedge clk);
                n_Rst = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                repeat (5) @(negedge clk);
                chk_all_zero("rst_hold");
                n_Rst = 1'b1;
            end
        join
        chk("rst_after_ready", 8'(data_ready), 8'h0);
        chk("rst_after_busy", 8'(busy), 8'h0);
        chk("rst_after_data", rx_data, 8'h00);
        send_frame(8'hA5, 1'b1, 0);
        chk("rst_a5_data", rx_data, 8'hA5);
        chk("rst_a5_ready", 8'(data_ready), 8'h1);
        chk("rst_a5_fe", 8'(framing_error), 8'h0);
        chk("rst_a5_ovr", 8'(overrun_error), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
